counter_sequencer: RTL
======================

// Module: counter_sequencer
// PURPOSE
//  Command-driven controller for the cascaded 16-bit modal counter (4x 4-bit stages; modo 00 up, 01 down,
//  10 down-by-3, 11 parallel load). Accepts one command (load value, mode, run length) per valid/ready
//  handshake, then sequences the counter through load, run and capture.
//  Reports final Q, the top-stage rco event count and an abort flag.
//  Sits between the system/bench command source and the counter's enb/modo/D/Q/rco pins.
// PARAMETERS
//  WIDTH    16  counter data width (D/Q)
//  NSTAGES  4   number of cascaded 4-bit stages (width of cnt_rco)
//  LEN_W    8   width of run-length field and of rco event counter
// PORTS
//  clk            in   1        system clock, rising edge
//  reset_L        in   1        asynchronous, active-low reset
//  cmd_valid      in   1        command present
//  cmd_ready      out  1        sequencer can accept command (high only in IDLE)
//  cmd_modo       in   2        counter mode for RUN phase
//  cmd_D          in   WIDTH    value loaded into counter in LOAD phase
//  cmd_len        in   LEN_W    number of RUN cycles (0 = load only)
//  abort          in   1        terminate current command early
//  cnt_enb        out  1        counter enable
//  cnt_modo       out  2        counter mode
//  cnt_D          out  WIDTH    counter parallel-load data
//  cnt_Q          in   WIDTH    counter output
//  cnt_rco        in   NSTAGES  per-stage rco; [NSTAGES-1] = whole-counter rco
//  busy           out  1        state != IDLE
//  done           out  1        one-cycle pulse: results valid
//  res_Q          out  WIDTH    cnt_Q captured at end of command
//  res_rco_count  out  LEN_W    RUN cycles with cnt_rco[NSTAGES-1]=1, saturating at all-ones
//  res_aborted    out  1        last command ended by abort
// BEHAVIOUR
//  Reset (reset_L=0, async): state IDLE; cnt_enb=0, cnt_modo=2'b11, cnt_D=0, done=0, res_Q=0,
//   res_rco_count=0, res_aborted=0; in-flight command dropped, no done issued.
//  FSM IDLE -> LOAD -> RUN -> CAPT -> IDLE; cnt_* outputs decoded from registered state/command regs.
//  IDLE: cmd_ready=1, cnt_enb=0, cnt_modo=11. Accept on cmd_valid&cmd_ready edge: latch modo/D/len,
//   clear rco counter and abort flag, -> LOAD. abort ignored in IDLE (even with cmd_valid).
//  LOAD (1 cycle): cnt_enb=1, cnt_modo=11, cnt_D=latched D; counter loads at cycle end.
//   Next: len==0 -> CAPT; else -> RUN with remaining=len.
//  RUN: cnt_enb=1, cnt_modo=latched modo (11 keeps reloading D). Each cycle: remaining-=1;
//   if cnt_rco[NSTAGES-1]=1 increment rco counter (saturate). remaining==1 -> CAPT next.
//  abort=1 in LOAD or RUN: current cycle's counter step still occurs; next state CAPT; res_aborted<=1.
//  CAPT (1 cycle): cnt_enb=0; res_Q<=cnt_Q and res_rco_count<=counter at cycle end; done<=1 -> high
//   exactly one cycle, coinciding with first IDLE cycle. res_* held until next capture.
//  Latency: accept edge -> done high in cycle len+3 after it (LOAD 1 + RUN len + CAPT 1 + 1).
//  Back-to-back: command accepted during done cycle; LOAD follows immediately, one idle cycle between.
//  Wrap-around is the counter's; sequencer does no arithmetic on Q. cnt_rco[NSTAGES-2:0] unused.
// TESTING
//  1 Up: D=16'hFFFE, modo=00, len=3 -> RUN Q FFFE,FFFF,0000; res_Q=16'h0001, rco_count=1, done cycle 6.
//  2 Down-3: D=16'h0009, modo=10, len=3 -> res_Q=16'h0000, rco_count=0, res_aborted=0.
//  3 Load-only: D=16'h1234, modo=01, len=0 -> no RUN cycle, res_Q=16'h1234, done cycle 3.
//  4 Abort: D=16'h0010, modo=01, len=10, abort high in 2nd RUN cycle -> res_Q=16'h000E, res_aborted=1.
//  5 Back-to-back: 2nd cmd valid during done cycle -> accepted that edge, busy low exactly 1 cycle.
//  6 reset_L low mid-RUN -> all outputs reset values immediately, no done; next cmd completes correctly.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven load/run/capture controller for a cascaded modal counter
// Ports: clk/reset_L clock and async active-low reset; cmd_valid/cmd_ready/cmd_modo/cmd_D/cmd_len command
// handshake; abort ends a command early; cnt_enb/cnt_modo/cnt_D drive the counter, cnt_Q/cnt_rco read it;
// busy/done/res_Q/res_rco_count/res_aborted report status and the captured result.
module counter_sequencer #(
  parameter int WIDTH   = 16,
  parameter int NSTAGES = 4,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_modo,
  input  logic [WIDTH-1:0]   cmd_D,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               abort,
  output logic               cnt_enb,
  output logic [1:0]         cnt_modo,
  output logic [WIDTH-1:0]   cnt_D,
  input  logic [WIDTH-1:0]   cnt_Q,
  input  logic [NSTAGES-1:0] cnt_rco,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   res_Q,
  output logic [LEN_W-1:0]   res_rco_count,
  output logic               res_aborted
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;
  state_t state, nxt;
  logic [1:0]       modo_r;
  logic [WIDTH-1:0] d_r;
  logic [LEN_W-1:0] rem, rco_cnt;
  logic             ab_r;
  logic             unused_rco;
  assign unused_rco = ^cnt_rco[NSTAGES-2:0];
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = cmd_valid ? LOAD : IDLE;
      LOAD: nxt = (abort || rem == '0) ? CAPT : RUN;
      RUN:  nxt = (abort || rem == LEN_W'(1)) ? CAPT : RUN;
      CAPT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = state == IDLE;
    busy      = state != IDLE;
    cnt_enb   = state == LOAD || state == RUN;
    cnt_modo  = state == RUN ? modo_r : 2'b11;
    cnt_D     = d_r;
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      modo_r        <= 2'b11;
      d_r           <= '0;
      rem           <= '0;
      rco_cnt       <= '0;
      ab_r          <= 1'b0;
      done          <= 1'b0;
      res_Q         <= '0;
      res_rco_count <= '0;
      res_aborted   <= 1'b0;
    end else begin
      done <= state == CAPT;
      if (state == IDLE && cmd_valid) begin
        modo_r  <= cmd_modo;
        d_r     <= cmd_D;
        rem     <= cmd_len;
        rco_cnt <= '0;
        ab_r    <= 1'b0;
      end
      if ((state == LOAD || state == RUN) && abort) ab_r <= 1'b1;
      if (state == RUN) begin
        rem <= rem - 1'b1;
        if (cnt_rco[NSTAGES-1] && !(&rco_cnt)) rco_cnt <= rco_cnt + 1'b1;
      end
      if (state == CAPT) begin
        res_Q         <= cnt_Q;
        res_rco_count <= rco_cnt;
        res_aborted   <= ab_r;
      end
    end
endmodule
